// File: rtl/uart.sv
// Full-duplex 8N1 UART: byte-wide host side, serial TX/RX pins, 16x oversampled receiver.
// Baud ticks (txen, rxen) are exposed for debug; TX2/LEDR mirror the line and received byte.
module uart #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200,
    parameter int TX_DIV   = CLK_FREQ / BAUD,
    parameter int RX_DIV   = CLK_FREQ / (16 * BAUD)
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] DATA_IN,
    input  logic       WR_EN,
    output logic       TX,
    output logic       TX_BUSY,
    input  logic       RX,
    output logic       READY,
    input  logic       READY_CLR,
    output logic [7:0] DATA_OUT,
    output logic [7:0] LEDR,
    output logic       TX2,
    output logic       rxen,
    output logic       txen
);
    localparam int TXW = $clog2(TX_DIV + 1);
    localparam int RXW = $clog2(RX_DIV + 1);
    localparam logic [TXW-1:0] TX_LAST = TXW'(TX_DIV - 1);
    localparam logic [RXW-1:0] RX_LAST = RXW'(RX_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t         tx_state;
    logic [TXW-1:0] tx_cnt;
    logic [7:0]     tx_shift;
    logic [2:0]     tx_idx;
    logic           tx_q;
    logic           busy_q;

    state_t         rx_state;
    logic [RXW-1:0] rx_cnt;
    logic           rx_meta;
    logic           rx_sync;
    logic [3:0]     rx_sample;
    logic [2:0]     rx_idx;
    logic [7:0]     rx_byte;
    logic [7:0]     data_q;
    logic           ready_q;

    // Handshake: WR_EN is taken only while TX_BUSY=0; READY stays high until READY_CLR.
    assign rxen = (rx_cnt == RX_LAST);
    assign txen = (tx_state != IDLE) && (tx_cnt == TX_LAST);

    always_ff @(posedge CLK) begin
        if (!RST_N || rxen) rx_cnt <= '0;
        else                rx_cnt <= rx_cnt + 1'b1;
    end

    // Held at zero while idle so the start bit gets a full TX_DIV period.
    always_ff @(posedge CLK) begin
        if (!RST_N || tx_state == IDLE || txen) tx_cnt <= '0;
        else                                    tx_cnt <= tx_cnt + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            tx_state <= IDLE;
            tx_shift <= '0;
            tx_idx   <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            case (tx_state)
                IDLE: if (WR_EN) begin
                    tx_shift <= DATA_IN;
                    tx_q     <= 1'b0;
                    busy_q   <= 1'b1;
                    tx_state <= START;
                end
                START: if (txen) begin
                    tx_idx   <= '0;
                    tx_q     <= tx_shift[0];
                    tx_state <= DATA;
                end
                DATA: if (txen) begin
                    if (tx_idx == 3'd7) begin
                        tx_q     <= 1'b1;
                        tx_state <= STOP;
                    end else begin
                        tx_idx <= tx_idx + 3'd1;
                        tx_q   <= tx_shift[tx_idx + 3'd1];
                    end
                end
                STOP: if (txen) begin
                    busy_q   <= 1'b0;
                    tx_state <= IDLE;
                end
                default: tx_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rx_state  <= IDLE;
            rx_sample <= '0;
            rx_idx    <= '0;
            rx_byte   <= '0;
            data_q    <= '0;
            ready_q   <= 1'b0;
        end else begin
            if (READY_CLR) ready_q <= 1'b0;
            if (rxen) begin
                case (rx_state)
                    IDLE: if (!rx_sync) begin
                        rx_sample <= '0;
                        rx_state  <= START;
                    end
                    START: begin
                        if (rx_sync) begin
                            rx_state <= IDLE;
                        end else if (rx_sample == 4'd7) begin
                            rx_sample <= '0;
                            rx_idx    <= '0;
                            rx_state  <= DATA;
                        end else begin
                            rx_sample <= rx_sample + 4'd1;
                        end
                    end
                    DATA: begin
                        rx_sample <= rx_sample + 4'd1;
                        if (rx_sample == 4'd15) begin
                            rx_byte[rx_idx] <= rx_sync;
                            if (rx_idx == 3'd7) rx_state <= STOP;
                            else                rx_idx   <= rx_idx + 3'd1;
                        end
                    end
                    STOP: begin
                        rx_sample <= rx_sample + 4'd1;
                        if (rx_sample == 4'd15) begin
                            // Placed after the clear above so a completing byte wins.
                            if (rx_sync) begin
                                data_q  <= rx_byte;
                                ready_q <= 1'b1;
                            end
                            rx_state <= IDLE;
                        end
                    end
                    default: rx_state <= IDLE;
                endcase
            end
        end
    end

    assign TX       = tx_q;
    assign TX2      = tx_q;
    assign TX_BUSY  = busy_q;
    assign READY    = ready_q;
    assign DATA_OUT = data_q;
    assign LEDR     = data_q;
endmodule

// File: tb/tb_uart.sv
// Bench for uart: line-level checks of transmitted frames plus a receive scoreboard
// fed by loopback and directly driven RX frames.
module tb_uart;
    localparam int TX_DIV = 48;
    localparam int RX_DIV = 3;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [7:0] DATA_IN;
    logic       WR_EN;
    logic       TX;
    logic       TX_BUSY;
    logic       READY;
    logic       READY_CLR;
    logic [7:0] DATA_OUT;
    logic [7:0] LEDR;
    logic       TX2;
    logic       rxen;
    logic       txen;
    logic       rx_drv;
    logic       lb;
    logic       rx_line;

    logic [7:0] exp_q[$];
    logic [7:0] last_rx;
    int         checks = 0;
    int         errors = 0;

    assign rx_line = lb ? TX : rx_drv;

    uart #(.CLK_FREQ(4800000), .BAUD(100000)) dut (
        .CLK(CLK), .RST_N(RST_N), .DATA_IN(DATA_IN), .WR_EN(WR_EN),
        .TX(TX), .TX_BUSY(TX_BUSY), .RX(rx_line), .READY(READY),
        .READY_CLR(READY_CLR), .DATA_OUT(DATA_OUT), .LEDR(LEDR),
        .TX2(TX2), .rxen(rxen), .txen(txen)
    );

    // Clock/reset
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every newly presented byte must match the head of the expected queue
    initial begin
        logic       ready_p = 1'b0;
        logic [7:0] data_p  = 8'h00;
        logic [7:0] e;
        forever begin
            @(negedge CLK);
            if (RST_N && READY && (!ready_p || DATA_OUT != data_p)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rx_unexpected: got 0x%0h expected no byte", DATA_OUT);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_data_out", DATA_OUT, e);
                    check("rx_ledr", LEDR, e);
                end
            end
            ready_p = READY;
            data_p  = DATA_OUT;
        end
    end

    // Driver tasks
    task automatic send_byte(input logic [7:0] b, input bit poke);
        logic [9:0] frame;
        int busy_n, txen_n;
        frame = {1'b1, b, 1'b0};
        exp_q.push_back(b);
        last_rx = b;
        @(negedge CLK);
        DATA_IN = b;
        WR_EN   = 1'b1;
        @(negedge CLK);
        WR_EN   = 1'b0;
        DATA_IN = 8'($urandom);
        busy_n = 0;
        txen_n = 0;
        for (int j = 0; j <= 10 * TX_DIV; j++) begin
            if (j > 0) @(negedge CLK);
            if (TX_BUSY) busy_n++;
            if (txen) txen_n++;
            if (j < 10 * TX_DIV && j % TX_DIV == TX_DIV / 2) begin
                check("tx_bit", TX, frame[j / TX_DIV]);
                check("tx2_bit", TX2, frame[j / TX_DIV]);
            end
            if (poke && j == 3 * TX_DIV) begin
                WR_EN   = 1'b1;
                DATA_IN = ~b;
            end else begin
                WR_EN = 1'b0;
            end
        end
        check("tx_busy_len", busy_n, 10 * TX_DIV);
        check("txen_count", txen_n, 10);
    endtask

    task automatic drive_rx_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        if (stop) begin
            exp_q.push_back(b);
            last_rx = b;
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            rx_drv = bits[k];
            repeat (TX_DIV - 1) @(negedge CLK);
        end
        rx_drv = 1'b1;
        repeat (2 * TX_DIV) @(negedge CLK);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!READY && n < 20 * TX_DIV) begin
            @(negedge CLK);
            n++;
        end
        check("ready_wait", READY, 1);
    endtask

    task automatic clear_ready();
        @(negedge CLK);
        READY_CLR = 1'b1;
        @(negedge CLK);
        READY_CLR = 1'b0;
        check("ready_clr", READY, 0);
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] seq[3];
        seq = '{8'h00, 8'h01, 8'h02};
        RST_N = 1'b0; WR_EN = 1'b0; DATA_IN = 8'h00; READY_CLR = 1'b0;
        rx_drv = 1'b1; lb = 1'b1; last_rx = 8'h00;
        repeat (4) @(negedge CLK);
        check("rst_tx", TX, 1);
        check("rst_busy", TX_BUSY, 0);
        check("rst_ready", READY, 0);
        check("rst_data_out", DATA_OUT, 0);
        check("rst_ledr", LEDR, 0);
        check("rst_txen", txen, 0);
        check("rst_rxen", rxen, 0);
        RST_N = 1'b1;

        // Loopback: fixed sequence then random bytes
        for (int i = 0; i < 3; i++) begin
            send_byte(seq[i], 1'b0);
            wait_ready();
            clear_ready();
        end
        for (int i = 0; i < 12; i++) begin
            send_byte(8'($urandom), 1'b0);
            wait_ready();
            clear_ready();
        end
        send_byte(8'hA5, 1'b1);
        wait_ready();
        clear_ready();

        // Direct RX: glitch, good frames, framing error
        lb = 1'b0;
        @(negedge CLK);
        rx_drv = 1'b0;
        repeat (3 * RX_DIV) @(negedge CLK);
        rx_drv = 1'b1;
        repeat (40 * RX_DIV) @(negedge CLK);
        check("glitch_ready", READY, 0);
        check("glitch_data", DATA_OUT, last_rx);

        for (int i = 0; i < 4; i++) begin
            drive_rx_frame(8'($urandom), 1'b1);
            wait_ready();
            clear_ready();
        end

        drive_rx_frame(8'h3C, 1'b0);
        check("frame_err_ready", READY, 0);
        check("frame_err_data", DATA_OUT, last_rx);

        // READY_CLR held while a byte completes: set must win
        b = 8'($urandom);
        fork
            drive_rx_frame(b, 1'b1);
            begin
                int n = 0;
                READY_CLR = 1'b1;
                while (!READY && n < 12 * TX_DIV) begin
                    @(negedge CLK);
                    n++;
                end
                READY_CLR = 1'b0;
                check("ready_set_wins", READY, 1);
            end
        join

        // New byte overwrites DATA_OUT while READY is still set
        drive_rx_frame(b ^ 8'($urandom_range(1, 255)), 1'b1);
        check("overwrite_ready", READY, 1);
        check("overwrite_data", DATA_OUT, last_rx);

        // Reset in the middle of a transmit
        lb = 1'b1;
        @(negedge CLK);
        DATA_IN = 8'h5A;
        WR_EN   = 1'b1;
        @(negedge CLK);
        WR_EN = 1'b0;
        repeat (2 * TX_DIV) @(negedge CLK);
        check("midtx_busy", TX_BUSY, 1);
        RST_N = 1'b0;
        @(negedge CLK);
        check("midrst_tx", TX, 1);
        check("midrst_busy", TX_BUSY, 0);
        check("midrst_ready", READY, 0);
        check("midrst_data", DATA_OUT, 0);
        RST_N = 1'b1;
        last_rx = 8'h00;
        repeat (TX_DIV) @(negedge CLK);

        send_byte(8'($urandom), 1'b0);
        wait_ready();
        clear_ready();

        repeat (TX_DIV) @(negedge CLK);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
